rr_arbiter_16: RTL and testbench

Round-robin arbiter that shares one 16-slot resource among 16 requesters. Examples of the resource: a TLB port, or a refill or invalidate engine. It issues a registered one-hot grant plus its 4-bit encoded index. It holds the grant until the owner signals completion or a programmable timeout forces release. The one-hot grant feeds the existing 16-way decode/encode fabric directly; the index drives 4-bit select paths.

---
 rtl/rr_arbiter_16.sv | 104 ++++++++++
 tb/tb_rr_arbiter_16.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with a held, registered one-hot grant.
// A grant is released by the owner's done strobe or force-released after TIMEOUT cycles.
module rr_arbiter_16 #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] req,
   input  logic        done,
   output logic [15:0] grant,
   output logic [3:0]  grant_idx,
   output logic        grant_valid,
   output logic        timeout_err
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] grant_q, grant_d;
   logic [3:0]  idx_q, idx_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   logic [3:0]  sel;
   logic [3:0]  cand;
   logic        found;

   // Rotating first-set search starting at ptr_q.
   always_comb begin
      sel   = 4'd0;
      cand  = 4'd0;
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cand = ptr_q + 4'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_d = 16'd1 << sel;
               idx_d   = sel;
               valid_d = 1'b1;
               cnt_d   = 8'd0;
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (done || cnt_q == 8'(TIMEOUT - 1)) begin
               // done has priority, so a coincident timeout is not flagged
               err_d   = ~done;
               grant_d = 16'd0;
               idx_d   = 4'd0;
               valid_d = 1'b0;
               ptr_d   = idx_q + 4'd1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= 4'd0;
         cnt_q   <= 8'd0;
         grant_q <= 16'd0;
         idx_q   <= 4'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = idx_q;
   assign grant_valid = valid_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16 with TIMEOUT=4; every output checked by immediate assertion.
module tb_rr_arbiter_16;

   logic        clk;
   logic        reset;
   logic [15:0] req;
   logic        done;
   logic [15:0] grant;
   logic [3:0]  grant_idx;
   logic        grant_valid;
   logic        timeout_err;

   int unsigned n_vec;
   int unsigned n_err;

   rr_arbiter_16 #(.TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] eg, input logic [3:0] ei,
                        input logic ev, input logic ee);
      n_vec++;
      assert (grant === eg) else begin
         n_err++;
         $error("FAIL %s grant: observed %h expected %h", tag, grant, eg);
      end
      n_vec++;
      assert (grant_idx === ei) else begin
         n_err++;
         $error("FAIL %s grant_idx: observed %0d expected %0d", tag, grant_idx, ei);
      end
      n_vec++;
      assert (grant_valid === ev) else begin
         n_err++;
         $error("FAIL %s grant_valid: observed %b expected %b", tag, grant_valid, ev);
      end
      n_vec++;
      assert (timeout_err === ee) else begin
         n_err++;
         $error("FAIL %s timeout_err: observed %b expected %b", tag, timeout_err, ee);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;

      // Reset held two cycles under full request and done
      reset = 1'b1; req = 16'hFFFF; done = 1'b1;
      tick(); check("rst1", 16'h0000, 4'd0, 1'b0, 1'b0);
      tick(); check("rst2", 16'h0000, 4'd0, 1'b0, 1'b0);
      reset = 1'b0; req = 16'h0000; done = 1'b1;
      tick(); check("rst_after", 16'h0000, 4'd0, 1'b0, 1'b0);
      done = 1'b0; req = 16'hFFFF;
      tick(); check("first_grant", 16'h0001, 4'd0, 1'b1, 1'b0);
      done = 1'b1; req = 16'h0000;
      tick(); check("first_rel", 16'h0000, 4'd0, 1'b0, 1'b0);   // ptr=1

      // Single requester, done in 3rd granted cycle
      done = 1'b0; req = 16'h0001;
      tick(); check("single_c1", 16'h0001, 4'd0, 1'b1, 1'b0);
      req = 16'h0000;                                           // owner drop ignored
      tick(); check("single_c2", 16'h0001, 4'd0, 1'b1, 1'b0);
      tick(); check("single_c3", 16'h0001, 4'd0, 1'b1, 1'b0);
      done = 1'b1;
      tick(); check("single_rel", 16'h0000, 4'd0, 1'b0, 1'b0);
      // done while idle is ignored
      tick(); check("idle_done", 16'h0000, 4'd0, 1'b0, 1'b0);

      // Fairness and wrap from ptr=0
      reset = 1'b1; done = 1'b0;
      tick(); reset = 1'b0; req = 16'hFFFF;
      for (int k = 0; k < 18; k++) begin
         done = 1'b0;
         tick(); check($sformatf("rr_grant%0d", k), 16'd1 << (k % 16), 4'(k % 16), 1'b1, 1'b0);
         done = 1'b1;
         tick(); check($sformatf("rr_idle%0d", k), 16'h0000, 4'd0, 1'b0, 1'b0);
      end

      // Pointer wrap: release idx 14 then req 0x4001 grants idx 0
      reset = 1'b1; done = 1'b0; req = 16'h0000;
      tick(); reset = 1'b0; req = 16'h4000;
      tick(); check("wrap_g14", 16'h4000, 4'd14, 1'b1, 1'b0);
      done = 1'b1;
      tick(); check("wrap_rel", 16'h0000, 4'd0, 1'b0, 1'b0);
      done = 1'b0; req = 16'h4001;
      tick(); check("wrap_g0", 16'h0001, 4'd0, 1'b1, 1'b0);
      done = 1'b1; req = 16'h0000;
      tick(); check("wrap_rel2", 16'h0000, 4'd0, 1'b0, 1'b0);

      // Timeout without done
      done = 1'b0; req = 16'h0100;
      for (int c = 1; c <= 4; c++) begin
         tick(); check($sformatf("to_c%0d", c), 16'h0100, 4'd8, 1'b1, 1'b0);
      end
      tick(); check("to_rel", 16'h0000, 4'd0, 1'b0, 1'b1);
      req = 16'h0000;
      tick(); check("to_pulse_end", 16'h0000, 4'd0, 1'b0, 1'b0);

      // Done coincident with the timeout cycle wins
      req = 16'h0100;
      for (int c = 1; c <= 4; c++) begin
         tick(); check($sformatf("tod_c%0d", c), 16'h0100, 4'd8, 1'b1, 1'b0);
      end
      done = 1'b1; req = 16'h0000;
      tick(); check("tod_rel", 16'h0000, 4'd0, 1'b0, 1'b0);
      done = 1'b0;
      tick(); check("tod_after", 16'h0000, 4'd0, 1'b0, 1'b0);

      // Reset mid-grant: idx 5 held with ptr=2
      req = 16'h0002;
      tick(); check("mid_g1", 16'h0002, 4'd1, 1'b1, 1'b0);
      done = 1'b1; req = 16'h0000;
      tick(); check("mid_rel1", 16'h0000, 4'd0, 1'b0, 1'b0);
      done = 1'b0; req = 16'h0020;
      tick(); check("mid_g5", 16'h0020, 4'd5, 1'b1, 1'b0);
      reset = 1'b1;
      tick(); check("mid_rst", 16'h0000, 4'd0, 1'b0, 1'b0);
      reset = 1'b0; req = 16'h0021;
      tick(); check("mid_g0", 16'h0001, 4'd0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
